// File: rtl/tlk_err_frame_sched_pkg.sv
// Shared types and constants for the TLK error-frame scheduler and its serialiser.
// TLK_FRAME_ID_EN selects an id-carrying header in place of the fixed two-zero header.
package tlk_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        STOP,
        GAP
    } state_t;

    localparam logic START_BIT   = 1'b1;
    localparam logic STOP_BIT    = 1'b0;
    localparam int   HDR_LEN_DEF = 2;

    // Start + header + payload + stop, excluding the idle gap.
    function automatic int frame_len(input int dw, input int idw, input bit id_en);
        return 1 + (id_en ? idw : HDR_LEN_DEF) + dw + 1;
    endfunction

endpackage

// File: rtl/tlk_err_frame_sched_if.sv
// Request/word bundle from the error collectors plus the serial status outputs.
// Latency and backpressure are set by the scheduler: req is held until its ack pulse.
interface tlk_err_frame_sched_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 18,
    parameter int IDW   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] din;
    logic [N_REQ-1:0]    ack;
    logic                q;
    logic                busy;
    logic [IDW-1:0]      cur_id;

    modport master (
        output req, din,
        input  ack, q, busy, cur_id
    );

    modport slave (
        input  req, din,
        output ack, q, busy, cur_id
    );
endinterface

// File: rtl/tlk_err_frame_sched_ser.sv
// Frame serialiser: start bit, header, payload LSB-first, stop bit, idle gap.
// Start bit appears the cycle after start; rdy is low from then until one idle cycle after the gap.
module tlk_frame_ser #(
    parameter int DW      = 18,
    parameter int HLEN    = 2,
    parameter int GAP_LEN = 8
) (
    input  logic            clk,
    input  logic            live,
    input  logic            start,
    input  logic [DW-1:0]   din,
    input  logic [HLEN-1:0] hdr,
    output logic            rdy,
    output logic            q,
    output logic            busy
);
    import tlk_frame_pkg::*;

    localparam int CW = $clog2(frame_len(DW, HLEN, 1'b1) + GAP_LEN + 1);

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [DW-1:0]   sh, sh_n;
    logic [HLEN-1:0] hsh, hsh_n;
    logic            q_n, busy_n;

    always_ff @(posedge clk) begin
        if (!live) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            hsh   <= '0;
            q     <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sh    <= sh_n;
            hsh   <= hsh_n;
            q     <= q_n;
            busy  <= busy_n;
        end
    end

    // q is registered, so each state emits the bit shown during the following cycle;
    // IDLE with busy still set is the cycle carrying the last gap bit.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        hsh_n   = hsh;
        q_n     = q;
        busy_n  = busy;
        case (state)
            IDLE: begin
                q_n = 1'b0;
                if (busy) begin
                    busy_n = 1'b0;
                end else if (start) begin
                    sh_n    = din;
                    hsh_n   = hdr;
                    q_n     = START_BIT;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = HDR;
                end
            end
            HDR: begin
                q_n   = hsh[0];
                hsh_n = hsh >> 1;
                if (cnt == CW'(HLEN - 1)) begin
                    cnt_n   = '0;
                    state_n = PAY;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PAY: begin
                q_n  = sh[0];
                sh_n = sh >> 1;
                if (cnt == CW'(DW - 1)) begin
                    cnt_n   = '0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                q_n     = STOP_BIT;
                cnt_n   = '0;
                state_n = (GAP_LEN == 0) ? IDLE : GAP;
            end
            GAP: begin
                q_n = 1'b0;
                if (cnt == CW'(GAP_LEN - 1)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                q_n     = 1'b0;
                busy_n  = 1'b0;
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign rdy = (state == IDLE) && !busy;

endmodule

// File: rtl/tlk_err_frame_sched.sv
// Round-robin scheduler sharing one serial status pin between N_REQ error sources (TLK_FRAME_ID_EN: id header).
// Grant one cycle after rdy+req, start bit with the ack pulse; requests outside the idle slot are ignored.
module tlk_err_frame_sched #(
    parameter int N_REQ = 4,
    parameter int DW    = 18,
    parameter int GAP   = 8
) (
    input  logic                 clk,
    input  logic                 LIVE,
    tlk_err_frame_sched_if.slave bus
);
    import tlk_frame_pkg::*;

    localparam int IDW = $clog2(N_REQ);
`ifdef TLK_FRAME_ID_EN
    localparam int HLEN = IDW;
`else
    localparam int HLEN = HDR_LEN_DEF;
`endif

    logic [IDW-1:0]   rr_ptr, gnt_idx, cur_id;
    logic [N_REQ-1:0] ack;
    logic [DW-1:0]    din_sel;
    logic [HLEN-1:0]  hdr_word;
    logic             found, start, rdy;

    // Search begins one past the last grant so every held requester gets a turn.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && bus.req[(int'(rr_ptr) + k) % N_REQ]) begin
                found   = 1'b1;
                gnt_idx = IDW'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        din_sel = bus.din[int'(gnt_idx)*DW +: DW];
`ifdef TLK_FRAME_ID_EN
        hdr_word = gnt_idx;
`else
        hdr_word = '0;
`endif
    end

    assign start = rdy && found;

    always_ff @(posedge clk) begin
        if (!LIVE) begin
            ack    <= '0;
            rr_ptr <= IDW'(N_REQ - 1);
            cur_id <= '0;
        end else begin
            ack <= '0;
            if (start) begin
                ack[gnt_idx] <= 1'b1;
                rr_ptr       <= gnt_idx;
                cur_id       <= gnt_idx;
            end
        end
    end

    tlk_frame_ser #(
        .DW      (DW),
        .HLEN    (HLEN),
        .GAP_LEN (GAP)
    ) u_ser (
        .clk   (clk),
        .live  (LIVE),
        .start (start),
        .din   (din_sel),
        .hdr   (hdr_word),
        .rdy   (rdy),
        .q     (bus.q),
        .busy  (bus.busy)
    );

    assign bus.ack    = ack;
    assign bus.cur_id = cur_id;

endmodule

// File: tb/tb_tlk_err_frame_sched.sv
// Scoreboard bench for tlk_err_frame_sched: drivers queue expected acks/frames, a negedge monitor checks them.
module tb_tlk_err_frame_sched;

    localparam int FLEN = 22;
    localparam int GAPL = 8;
    localparam int TOT  = FLEN + GAPL;
`ifdef TLK_FRAME_ID_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    typedef struct packed {
        logic [TOT-1:0] bits;
        logic [1:0]     id;
        logic [7:0]     spacing;
        logic           abort_ok;
    } exp_t;

    logic clk = 1'b0;
    logic live;
    logic live_at_edge = 1'b0;
    int   cyc = 0;

    tlk_err_frame_sched_if #(.N_REQ(4), .DW(18)) bus ();

    tlk_err_frame_sched #(.N_REQ(4), .DW(18), .GAP(GAPL)) dut (
        .clk  (clk),
        .LIVE (live),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        live_at_edge <= live;
    end

    int n_chk = 0, n_pass = 0;
    exp_t       exp_q[$];
    logic [3:0] ack_q[$];
    int frames_exp = 0, frames_seen = 0, acks_exp = 0, acks_seen = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, want);
    endtask

    task automatic fail_evt(input string nm, input logic [63:0] act);
        n_chk++;
        $display("FAIL %s: got %0h expected none", nm, act);
    endtask

    function automatic logic [1:0] exp_hdr(input logic [1:0] id);
        return ID_EN ? id : 2'b00;
    endfunction

    function automatic logic [TOT-1:0] mk_frame(input logic [1:0] id, input logic [17:0] pay);
        logic [TOT-1:0] f;
        logic [1:0]     h;
        f    = '0;
        h    = exp_hdr(id);
        f[0] = 1'b1;
        f[1] = h[0];
        f[2] = h[1];
        for (int i = 0; i < 18; i++) f[3+i] = pay[i];
        f[21] = 1'b0;
        return f;
    endfunction

    task automatic push_frame(input logic [1:0] id, input logic [17:0] pay, input int spacing, input logic ab);
        exp_t e;
        logic [3:0] one;
        one        = 4'b0001;
        e.bits     = mk_frame(id, pay);
        e.id       = id;
        e.spacing  = 8'(spacing);
        e.abort_ok = ab;
        exp_q.push_back(e);
        ack_q.push_back(one << id);
        frames_exp++;
        acks_exp++;
    endtask

    // Monitor
    exp_t           cur;
    logic           have_exp = 1'b0, in_frame = 1'b0, prev_busy = 1'b0;
    logic [TOT-1:0] cap, pmask;
    int             idx = 0, last_start = 0;

    always @(negedge clk) begin
        if (!live_at_edge) begin
            chk("rst_q", 64'(bus.q), 64'd0);
            chk("rst_ack", 64'(bus.ack), 64'd0);
            chk("rst_busy", 64'(bus.busy), 64'd0);
            if (in_frame && have_exp) begin
                pmask = '0;
                for (int i = 0; i < TOT; i++) if (i < idx) pmask[i] = 1'b1;
                chk("abort_allowed", 64'(cur.abort_ok), 64'd1);
                chk("abort_prefix", 64'((cap ^ cur.bits) & pmask), 64'd0);
            end
            in_frame  = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (bus.ack != 4'b0000) begin
                acks_seen++;
                if (ack_q.size() == 0) fail_evt("unexpected_ack", 64'(bus.ack));
                else chk("ack", 64'(bus.ack), 64'(ack_q.pop_front()));
            end
            if (bus.busy && !prev_busy) begin
                frames_seen++;
                in_frame = 1'b1;
                idx      = 0;
                cap      = '0;
                if (exp_q.size() == 0) begin
                    have_exp = 1'b0;
                    fail_evt("unexpected_frame", 64'(bus.cur_id));
                end else begin
                    have_exp = 1'b1;
                    cur      = exp_q.pop_front();
                    chk("cur_id", 64'(bus.cur_id), 64'(cur.id));
                    if (cur.spacing != 0)
                        chk("start_spacing", 64'(cyc - last_start), 64'(cur.spacing));
                end
                last_start = cyc;
            end
            if (in_frame && bus.busy) begin
                if (idx < TOT) cap[idx] = bus.q;
                idx++;
            end
            if (in_frame && !bus.busy) begin
                if (have_exp) begin
                    chk("frame_bits", 64'(cap), 64'(cur.bits));
                    chk("busy_len", 64'(idx), 64'(TOT));
                end
                in_frame = 1'b0;
            end
            prev_busy = bus.busy;
        end
    end

    // Drivers
    task automatic wait_ack(input int id);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus.ack[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_evt("ack_timeout", 64'(id));
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && ack_q.size() == 0 && !in_frame && !bus.busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) fail_evt("drain_timeout", 64'(exp_q.size()));
    endtask

    task automatic send_one(input int id, input logic [17:0] d);
        push_frame(2'(id), d, 0, 1'b0);
        bus.din[id*18 +: 18] = d;
        bus.req[id] = 1'b1;
        wait_ack(id);
        bus.req[id] = 1'b0;
        bus.din[id*18 +: 18] = ~d;
    endtask

    task automatic pulse_reset(input int n);
        live = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        live = 1'b1;
    endtask

    logic [17:0] dv [4] = '{18'h11111, 18'h22222, 18'h33333, 18'h04444};

    initial begin
        int got;
        live    = 1'b0;
        bus.req = 4'hF;
        bus.din = {4{18'h3FFFF}};
        repeat (3) @(posedge clk);
        #1;
        live    = 1'b1;
        bus.req = 4'h0;

        send_one(0, 18'h2A5A5);
        drain();

        pulse_reset(2);
        for (int i = 0; i < 4; i++) bus.din[i*18 +: 18] = dv[i];
        push_frame(2'd0, dv[0], 0, 1'b0);
        push_frame(2'd1, dv[1], 31, 1'b0);
        push_frame(2'd2, dv[2], 31, 1'b0);
        push_frame(2'd3, dv[3], 31, 1'b0);
        push_frame(2'd0, dv[0], 31, 1'b0);
        bus.req = 4'hF;
        got = 0;
        for (int i = 0; i < 300 && got < 5; i++) begin
            @(posedge clk); #1;
            if (bus.ack != 4'b0000) got++;
        end
        if (got < 5) fail_evt("rr_ack_timeout", 64'(got));
        bus.req = 4'h0;
        drain();

        push_frame(2'd1, 18'h3C0F1, 0, 1'b1);
        bus.din[18 +: 18] = 18'h3C0F1;
        bus.req[1] = 1'b1;
        wait_ack(1);
        bus.req[1] = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        push_frame(2'd0, dv[0], 0, 1'b0);
        bus.req = 4'hF;
        pulse_reset(2);
        wait_ack(0);
        bus.req = 4'h0;
        drain();

        push_frame(2'd0, 18'h15555, 0, 1'b0);
        bus.din[0 +: 18] = 18'h15555;
        bus.req[0] = 1'b1;
        wait_ack(0);
        bus.req[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.req[1] = 1'b1;
        @(posedge clk);
        #1;
        bus.req[1] = 1'b0;
        drain();

        send_one(2, 18'h00000);
        drain();

        repeat (40) @(posedge clk);
        #1;
        chk("frames_seen", 64'(frames_seen), 64'(frames_exp));
        chk("acks_seen", 64'(acks_seen), 64'(acks_exp));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
